// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor family.
package serial_arith_pkg;

    localparam int DEFAULT_WORDWIDTH = 8;

    typedef enum logic {
        LOAD  = 1'b0,
        SHIFT = 1'b1
    } serial_state_e;

    // Bit counter width; never less than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_full_subtractor.sv
// Single-bit full subtractor cell, purely combinational: d = a - b - bin.
module serial_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_top.sv
// Free-running LSB-first serial subtractor: out = a_in - b_in, done WORDWIDTH+1 clocks after LOAD; no backpressure.
// SERIAL_SUB_SATURATE_EN clamps a borrowing result to zero.
module serial_subtractor_top
    import serial_arith_pkg::*;
#(
    parameter int WORDWIDTH = DEFAULT_WORDWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORDWIDTH-1:0] a_in,
    input  logic [WORDWIDTH-1:0] b_in,
    output logic [WORDWIDTH-1:0] out,
    output logic                 bout,
    output logic                 done
);

    localparam int            CW   = cnt_width(WORDWIDTH);
    localparam logic [CW-1:0] LAST = CW'(WORDWIDTH - 1);

    serial_state_e        state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORDWIDTH-1:0] a_sr_q, a_sr_d;
    logic [WORDWIDTH-1:0] b_sr_q, b_sr_d;
    logic [WORDWIDTH-1:0] res_q, res_d;
    logic                 borrow_q, borrow_d;
    logic [WORDWIDTH-1:0] out_q, out_d;
    logic                 bout_q, bout_d;
    logic                 done_q, done_d;

    logic                 diff_bit;
    logic                 borrow_nxt;
    logic [WORDWIDTH-1:0] res_next;
    logic [WORDWIDTH-1:0] final_res;

    serial_full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (diff_bit),
        .bout (borrow_nxt)
    );

    // Difference bits enter at the MSB so the LSB lands in bit 0 after WORDWIDTH shifts.
    assign res_next = {diff_bit, res_q[WORDWIDTH-1:1]};

`ifdef SERIAL_SUB_SATURATE_EN
    assign final_res = borrow_nxt ? '0 : res_next;
`else
    assign final_res = res_next;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        out_d    = out_q;
        bout_d   = bout_q;
        done_d   = 1'b0;
        case (state_q)
            LOAD: begin
                a_sr_d   = a_in;
                b_sr_d   = b_in;
                borrow_d = 1'b0;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = borrow_nxt;
                res_d    = res_next;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = LOAD;
                    out_d   = final_res;
                    bout_d  = borrow_nxt;
                    done_d  = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            out_q    <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            out_q    <= out_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
        end
    end

    assign out  = out_q;
    assign bout = bout_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor_top.sv
// Directed and randomized checks of the 8-bit serial subtractor.
module tb_serial_subtractor_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] out;
    logic       bout;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [7:0] prev_out;
    logic       prev_bout;

    always #5 clk = ~clk;

    serial_subtractor_top #(.WORDWIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .out   (out),
        .bout  (bout),
        .done  (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] adj(input logic [7:0] d, input logic b);
`ifdef SERIAL_SUB_SATURATE_EN
        return b ? 8'd0 : d;
`else
        return d;
`endif
    endfunction

    // Called during a LOAD cycle; ends in the next LOAD cycle (the done cycle).
    task automatic frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_out, input logic exp_bout,
                         input bit scramble, input string tag);
        a_in = a;
        b_in = b;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check({tag, "_done_low"}, {31'd0, done}, 32'd0);
            if (scramble) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end
        end
        check({tag, "_out_hold"}, {24'd0, out}, {24'd0, prev_out});
        check({tag, "_bout_hold"}, {31'd0, bout}, {31'd0, prev_bout});
        tick();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_out"}, {24'd0, out}, {24'd0, adj(exp_out, exp_bout)});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bout});
        prev_out  = adj(exp_out, exp_bout);
        prev_bout = exp_bout;
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst_n     = 1'b0;
        a_in      = 8'd0;
        b_in      = 8'd0;
        prev_out  = 8'd0;
        prev_bout = 1'b0;
        tick();
        tick();
        check("reset_out", {24'd0, out}, 32'd0);
        check("reset_bout", {31'd0, bout}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        rst_n = 1'b1;
        frame(8'd200, 8'd100, 8'd100, 1'b0, 1'b0, "s200_100");
        frame(8'd100, 8'd200, 8'd156, 1'b1, 1'b0, "s100_200");
        frame(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, "s0_0");
        frame(8'd255, 8'd1,   8'd254, 1'b0, 1'b0, "s255_1");
        frame(8'd0,   8'd1,   8'd255, 1'b1, 1'b0, "s0_1");
        frame(8'd85,  8'd85,  8'd0,   1'b0, 1'b0, "s85_85");
        frame(8'd200, 8'd100, 8'd100, 1'b0, 1'b1, "scr200_100");
        frame(8'd17,  8'd240, 8'd33,  1'b1, 1'b1, "scr17_240");
        frame(8'd255, 8'd1,   8'd254, 1'b0, 1'b0, "pre_rst");

        // Abort a frame at shift counter 4.
        a_in = 8'd9;
        b_in = 8'd3;
        tick();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out", {24'd0, out}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        prev_out  = 8'd0;
        prev_bout = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("abort_hold_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        frame(8'd9, 8'd3, 8'd6, 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            frame(ra, rb, 8'(ra - rb), (ra < rb), 1'b1, "soak");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_top.md
Name: serial_subtractor_top

Overview:
- Bit-serial two's-complement subtractor. It is the inverse of the existing serial adder and serves as the comb/differentiator arithmetic element for the CIC datapath.
- Captures parallel words a_in and b_in, then computes a_in - b_in LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flop.
- Re-parallelizes the result and presents it on out, with a one-cycle done pulse per frame.
- Free-running: one complete subtraction every WORDWIDTH+1 clocks.

Parameters:
- WORDWIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset; asynchronous, active-low.
- a_in  input  WORDWIDTH  minuend; sampled only in the LOAD cycle.
- b_in  input  WORDWIDTH  subtrahend; sampled only in the LOAD cycle.
- out  output  WORDWIDTH  registered difference of the most recently completed frame.
- bout  output  1  registered final borrow of that frame; 1 means a_in < b_in (unsigned).
- done  output  1  high for exactly one clk when out/bout have just updated.

Behaviour:
- Reset (rst_n=0, asynchronous) drives these values:
  - out=0, bout=0, done=0.
  - Operand shift registers, result shift register and borrow flop all 0.
  - Bit counter = 0; FSM = LOAD.
- FSM states: LOAD, SHIFT. No idle state; the block runs continuously whenever rst_n=1.
- LOAD (1 cycle):
  - a_sr <= a_in, b_sr <= b_in, borrow <= 0, bit counter <= 0.
  - Next state is SHIFT.
- SHIFT (WORDWIDTH cycles, counter 0..WORDWIDTH-1):
  - diff_bit = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - a_sr and b_sr shift right by one.
  - diff_bit enters the result shift register at the MSB and the register shifts right, so after WORDWIDTH shifts bit 0 holds the LSB.
  - When counter = WORDWIDTH-1, the next state is LOAD.
- Output update, on the clock edge that leaves the last SHIFT cycle:
  - out <= completed result; bout <= borrow_next.
  - done is high during the following cycle, which is the next frame's LOAD cycle.
  - done is low in every other cycle.
- Timing:
  - Latency from the LOAD-cycle sample to done is WORDWIDTH+1 clocks.
  - The first done after reset release occurs on the (WORDWIDTH+1)th rising edge.
  - The period between done pulses is exactly WORDWIDTH+1 clocks.
- Arithmetic: modulo 2^WORDWIDTH. out = (a_in - b_in) mod 2^WORDWIDTH; bout = borrow out of the MSB.
- Boundary conditions:
  - Changes on a_in/b_in outside the LOAD cycle have no effect on the current frame.
  - a_in = b_in gives out=0, bout=0.
  - Reset asserted mid-frame aborts the frame: out is cleared, no done pulse, and the FSM restarts at LOAD after release.
- out and bout hold their values between done pulses.

Optional Feature:
- Macro: SERIAL_SUB_SATURATE_EN.
- When defined: if the final borrow is 1, out <= 0 instead of the wrapped result. bout is still 1 and the timing is unchanged.
- When undefined: wrap-around result as specified above. No saturation logic is synthesized.

Decomposition:
- Package serial_arith_pkg, shared with the serial adder:
  - state enum (LOAD, SHIFT);
  - localparam DEFAULT_WORDWIDTH = 8;
  - counter-width function based on $clog2(WORDWIDTH).
- Sub-module serial_full_subtractor: combinational cell with inputs a, b, bin and outputs d, bout. The top module holds the borrow flop.

Test Plan:
- a_in=200, b_in=100, WORDWIDTH=8; release reset -> first done on the 9th edge; out=100, bout=0.
- a_in=100, b_in=200 -> out=156, bout=1. With SERIAL_SUB_SATURATE_EN: out=0, bout=1.
- Corner operand pairs, each -> expected out, bout:
  - 0-0 -> 0, 0.
  - 255-1 -> 254, 0.
  - 0-1 -> 255, 1.
  - 85-85 -> 0, 0.
  - Check that done pulses are exactly 9 clocks apart.
- Toggle a_in/b_in to random values during SHIFT cycles -> the result matches only the LOAD-cycle operands.
- Assert rst_n=0 at SHIFT counter=4 -> out, bout and done go to 0 immediately, with no done in that frame; the next done arrives 9 edges after release.
- Random soak of 1000 frames against a reference model (a-b) mod 256 with borrow -> zero mismatches.
